alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_mul_iter.sv | 42 ++++
 rtl/alu_seq.sv | 104 ++++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag-index and state types shared by the sequential ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_MOV, OP_CMP, OP_TEST, OP_SHL, OP_SHR, OP_ADD, OP_ADC,
    OP_SUB, OP_SBB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CLRF
  } op_t;
  typedef enum int unsigned {FLAG_V = 4, FLAG_C = 5, FLAG_S = 6, FLAG_Z = 7} flag_t;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
  parameter int WORD_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   a,
  input  logic [WORD_SIZE-1:0]   b,
  output logic                   done,
  output logic [2*WORD_SIZE-1:0] product
);
  logic [2*WORD_SIZE-1:0] mcand;
  logic [WORD_SIZE-1:0] mplier;
  logic [5:0] cnt;
  logic busy;
  // bit 0 is folded into the load so the remaining WORD_SIZE-1 bits finish in time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      product <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      product <= b[0] ? {{WORD_SIZE{1'b0}}, a} : '0;
      mcand <= {{(WORD_SIZE-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt <= 6'(WORD_SIZE - 1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      product <= product + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 6'd1;
      busy <= cnt != 6'd1;
      done <= cnt == 6'd1;
    end else
      done <= 1'b0;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked 16-opcode ALU with registered result/flags and iterative MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           mode_select,
  input  logic [WORD_SIZE-1:0] input_A,
  input  logic [WORD_SIZE-1:0] input_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] output_C,
  output logic [7:0]           flags
);
  localparam int msb = WORD_SIZE - 1;
  localparam logic [WORD_SIZE-1:0] w_lim = WORD_SIZE'(WORD_SIZE);
  state_t state, state_nx;
  op_t op;
  logic live, acc, mul_done, wr_c, wr_f, clr, cf, vf, big;
  logic [WORD_SIZE-1:0] r;
  logic [WORD_SIZE:0] sum, dif, shl, shr;
  logic [2*WORD_SIZE-1:0] prod;
  logic [7:0] f_nx;
  assign op = op_t'(mode_select);
  // live keeps in_ready low until the first edge after reset release
  assign in_ready = live && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = state == DONE;
  assign acc = in_valid && in_ready;
  assign sum = {1'b0, input_A} + {1'b0, input_B} + (WORD_SIZE+1)'(op == OP_ADC && flags[FLAG_C]);
  assign dif = {1'b0, input_A} - {1'b0, input_B} - (WORD_SIZE+1)'(op == OP_SBB && flags[FLAG_C]);
  assign shl = {1'b0, input_A} << input_B;
  assign shr = {input_A, 1'b0} >> input_B;
  assign big = input_B >= w_lim;
  alu_mul_iter #(.WORD_SIZE(WORD_SIZE)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(acc && op == OP_MUL),
    .a(input_A),
    .b(input_B),
    .done(mul_done),
    .product(prod)
  );
  always_comb begin
    r = output_C;
    cf = 1'b0;
    vf = 1'b0;
    wr_c = 1'b0;
    wr_f = 1'b0;
    clr = 1'b0;
    state_nx = acc ? (op == OP_MUL ? MUL : DONE)
             : state == MUL && mul_done ? DONE
             : state == DONE && out_ready ? IDLE : state;
    if (state == MUL) begin
      r = prod[msb:0];
      cf = |prod[2*WORD_SIZE-1:WORD_SIZE];
      vf = cf;
      wr_c = mul_done;
      wr_f = mul_done;
    end else if (acc)
      unique case (op)
        OP_MOV: begin r = input_B; wr_c = 1'b1; end
        OP_CMP, OP_SUB, OP_SBB: begin
          r = dif[msb:0];
          cf = dif[WORD_SIZE];
          vf = (input_A[msb] != input_B[msb]) && (dif[msb] != input_A[msb]);
          wr_c = op != OP_CMP;
          wr_f = 1'b1;
        end
        OP_ADD, OP_ADC: begin
          r = sum[msb:0];
          cf = sum[WORD_SIZE];
          vf = (input_A[msb] == input_B[msb]) && (sum[msb] != input_A[msb]);
          wr_c = 1'b1;
          wr_f = 1'b1;
        end
        OP_SHL: begin r = big ? '0 : shl[msb:0]; cf = !big && shl[WORD_SIZE]; wr_c = 1'b1; wr_f = 1'b1; end
        OP_SHR: begin r = big ? '0 : shr[WORD_SIZE:1]; cf = !big && shr[0]; wr_c = 1'b1; wr_f = 1'b1; end
        OP_TEST: begin r = input_A & input_B; wr_f = 1'b1; end
        OP_AND: begin r = input_A & input_B; wr_c = 1'b1; wr_f = 1'b1; end
        OP_OR: begin r = input_A | input_B; wr_c = 1'b1; wr_f = 1'b1; end
        OP_XOR: begin r = input_A ^ input_B; wr_c = 1'b1; wr_f = 1'b1; end
        OP_NOT: begin r = ~input_A; wr_c = 1'b1; wr_f = 1'b1; end
        OP_CLRF: begin wr_f = 1'b1; clr = 1'b1; end
        default: ;
      endcase
    f_nx = clr ? 8'h00 : {r == '0, r[msb], cf, vf, 4'h0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      output_C <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      if (wr_c) output_C <= r;
      if (wr_f) flags <= f_nx;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (WORD_SIZE=8)
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] mode_select = 4'd0;
  logic [7:0] input_A = 8'h00;
  logic [7:0] input_B = 8'h00;
  logic in_ready, out_valid;
  logic [7:0] output_C, flags;
  int tests = 0;
  int fails = 0;

  alu_seq #(.WORD_SIZE(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode_select(mode_select),
    .input_A(input_A),
    .input_B(input_B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .output_C(output_C),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at a negedge with the result consumed
  task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ec, input logic [7:0] ef, input int lat, input string tag);
    int n;
    chk(in_ready, 1, {tag, "_rdy"});
    in_valid = 1'b1;
    mode_select = op;
    input_A = a;
    input_B = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 40) begin
      chk(in_ready, 0, {tag, "_busy_rdy"});
      @(negedge clk);
      n++;
    end
    chk(n, lat, {tag, "_lat"});
    chk(output_C, ec, {tag, "_C"});
    chk(flags, ef, {tag, "_flags"});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk(out_valid, 0, "rst_ov");
    chk(in_ready, 0, "rst_rdy");
    chk(output_C, 0, "rst_C");
    chk(flags, 0, "rst_flags");
    rst_n = 1'b1;
    #1 chk(in_ready, 0, "rel_rdy");
    @(negedge clk);
    chk(in_ready, 1, "post_rst_rdy");

    run(4'd6, 8'h7F, 8'h01, 8'h80, 8'h50, 1, "add_ovf");
    run(4'd8, 8'h05, 8'h07, 8'hFE, 8'h60, 1, "sub_borrow");
    run(4'd6, 8'hFF, 8'h01, 8'h00, 8'hA0, 1, "add_carry");
    run(4'd7, 8'h00, 8'h00, 8'h01, 8'h00, 1, "adc_cin");
    run(4'd8, 8'h00, 8'h01, 8'hFF, 8'h60, 1, "sub_ff");
    run(4'd9, 8'h05, 8'h02, 8'h02, 8'h00, 1, "sbb_cin");
    run(4'd10, 8'h10, 8'h10, 8'h00, 8'hB0, 9, "mul_hi");
    run(4'd10, 8'h03, 8'h05, 8'h0F, 8'h00, 9, "mul_lo");
    run(4'd4, 8'h81, 8'h01, 8'h02, 8'h20, 1, "shl1");
    run(4'd5, 8'h81, 8'h08, 8'h00, 8'h80, 1, "shr8");
    run(4'd5, 8'h81, 8'h01, 8'h40, 8'h20, 1, "shr1");
    run(4'd4, 8'h81, 8'h00, 8'h81, 8'h40, 1, "shl0");
    run(4'd1, 8'h00, 8'h55, 8'h55, 8'h40, 1, "mov");
    run(4'd2, 8'h10, 8'h20, 8'h55, 8'h60, 1, "cmp");
    run(4'd3, 8'h0F, 8'hF0, 8'h55, 8'h80, 1, "test");
    run(4'd11, 8'hF0, 8'h3C, 8'h30, 8'h00, 1, "and");
    run(4'd12, 8'h80, 8'h01, 8'h81, 8'h40, 1, "or");
    run(4'd13, 8'hFF, 8'hFF, 8'h00, 8'h80, 1, "xor");
    run(4'd14, 8'h0F, 8'h00, 8'hF0, 8'h40, 1, "not");
    run(4'd0, 8'h12, 8'h34, 8'hF0, 8'h40, 1, "nop");
    run(4'd15, 8'h00, 8'h00, 8'hF0, 8'h00, 1, "clrf");
    run(4'd6, 8'h80, 8'h80, 8'h00, 8'hB0, 1, "add_negovf");
    run(4'd8, 8'h80, 8'h01, 8'h7F, 8'h10, 1, "sub_ovf");

    // hold: result stays put and a new offer is refused while out_ready=0
    in_valid = 1'b1;
    mode_select = 4'd6;
    input_A = 8'h11;
    input_B = 8'h22;
    @(posedge clk);
    #1 input_A = 8'h01;
    input_B = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(output_C, 8'h33, "hold_C");
      chk(flags, 8'h00, "hold_flags");
      chk(out_valid, 1, "hold_ov");
      chk(in_ready, 0, "hold_rdy");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk(out_valid, 0, "hold_drain");
    out_ready = 1'b0;

    // back-to-back: one ADD retired and one accepted per cycle
    in_valid = 1'b1;
    out_ready = 1'b1;
    mode_select = 4'd6;
    input_A = 8'd1;
    input_B = 8'd1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk(out_valid, 1, "b2b_ov");
      chk(output_C, 2 * i, "b2b_C");
      input_A = 8'(i + 1);
      input_B = 8'(i + 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid, 0, "b2b_end");
    out_ready = 1'b0;

    // reset during MUL: everything clears at once and the MUL never completes
    run(4'd6, 8'h80, 8'h80, 8'h00, 8'hB0, 1, "pre_rst");
    in_valid = 1'b1;
    mode_select = 4'd10;
    input_A = 8'h10;
    input_B = 8'h10;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(out_valid, 0, "mulrst_ov");
    chk(flags, 0, "mulrst_flags");
    chk(output_C, 0, "mulrst_C");
    chk(in_ready, 0, "mulrst_rdy");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    chk(seen, 0, "mulrst_no_result");
    chk(flags, 0, "mulrst_flags_after");
    run(4'd6, 8'h01, 8'h02, 8'h03, 8'h00, 1, "post_rst_add");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
